// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared constants, state encoding and helpers for the seq_divider32 block.
//   DIV_W       : operand width
//   DIV_ITER    : quotient bits produced, one per RUN cycle
//   DIV_LATENCY : accept-to-result latency in cycles (full-length divide)
//   CNT_W       : width of the iteration counter (must hold DIV_ITER)
// -----------------------------------------------------------------------------
package divider_pkg;

  localparam int DIV_W       = 32;
  localparam int DIV_ITER    = 32;
  localparam int DIV_LATENCY = DIV_ITER + 2;
  localparam int CNT_W       = $clog2(DIV_ITER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Absolute value for two's-complement operands; pass-through for unsigned.
  // -(0x80000000) wraps back to 0x80000000, which is the correct unsigned
  // magnitude of the most negative number.
  function automatic logic [DIV_W-1:0] magnitude(input logic [DIV_W-1:0] x,
                                                 input logic             is_signed);
    return (is_signed && x[DIV_W-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/div_core_unsigned.sv
// -----------------------------------------------------------------------------
// div_core_unsigned
// Radix-2 restoring division engine working on unsigned magnitudes.
// One quotient bit is retired per 'step'; after DIV_ITER steps 'quotient' and
// 'remainder' hold the final magnitudes.
//   aclk      in   clock
//   resetn    in   asynchronous active-low reset
//   load      in   capture dividend/divisor and clear the partial remainder
//   step      in   perform one shift/subtract iteration
//   dividend  in   DIV_W  dividend magnitude
//   divisor   in   DIV_W  divisor magnitude
//   quotient  out  DIV_W  quotient magnitude
//   remainder out  DIV_W  remainder magnitude
// -----------------------------------------------------------------------------
module div_core_unsigned
  import divider_pkg::*;
(
  input  logic             aclk,
  input  logic             resetn,
  input  logic             load,
  input  logic             step,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder
);

  // The quotient register doubles as the dividend shift register: dividend
  // bits leave at the MSB while quotient bits enter at the LSB.
  logic [DIV_W-1:0] quo_q;
  logic [DIV_W-1:0] rem_q;
  logic [DIV_W-1:0] dsr_q;
  logic [DIV_W:0]   shifted;
  logic [DIV_W:0]   diff;
  logic             borrow;

  always_comb begin
    shifted = {rem_q, quo_q[DIV_W-1]};
    diff    = shifted - {1'b0, dsr_q};
    // Partial remainder is always below the divisor, so a set MSB of the
    // 33-bit difference can only mean the trial subtraction went negative.
    borrow  = diff[DIV_W];
  end

  // NOTE: datapath registers take an async reset too; they are few and a
  // known post-reset value keeps X out of the output muxes.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dsr_q <= divisor;
    end else if (step) begin
      rem_q <= borrow ? shifted[DIV_W-1:0] : diff[DIV_W-1:0];
      quo_q <= {quo_q[DIV_W-2:0], ~borrow};
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/seq_divider32.sv
// -----------------------------------------------------------------------------
// seq_divider32
// Iterative 32-bit divider for MIPS DIV/DIVU with a valid-only stream
// handshake. Operands are accepted when both input valids are high and the
// unit is idle; the result appears as a one-cycle m_axis_dout_tvalid pulse.
// m_axis_dout_tdata = {remainder, quotient} (HI, LO). tdata/tuser hold until
// the next completion.
//   SIGNED                 param  1: two's-complement (div), 0: unsigned (divu)
//   aclk                   in     clock
//   resetn                 in     asynchronous active-low reset
//   s_axis_divisor_tvalid  in     divisor valid
//   s_axis_divisor_tdata   in 32  divisor
//   s_axis_dividend_tvalid in     dividend valid
//   s_axis_dividend_tdata  in 32  dividend
//   m_axis_dout_tvalid     out    one-cycle result pulse
//   m_axis_dout_tuser      out    divide-by-zero flag
//   m_axis_dout_tdata      out 64 {remainder, quotient}
// Build option: DIV_ZERO_FASTPATH_EN -- a zero divisor skips the iterations
// and completes in 2 cycles instead of DIV_LATENCY.
// -----------------------------------------------------------------------------
module seq_divider32
  import divider_pkg::*;
#(
  parameter bit SIGNED = 1'b0
) (
  input  logic                 aclk,
  input  logic                 resetn,
  input  logic                 s_axis_divisor_tvalid,
  input  logic [DIV_W-1:0]     s_axis_divisor_tdata,
  input  logic                 s_axis_dividend_tvalid,
  input  logic [DIV_W-1:0]     s_axis_dividend_tdata,
  output logic                 m_axis_dout_tvalid,
  output logic                 m_axis_dout_tuser,
  output logic [2*DIV_W-1:0]   m_axis_dout_tdata
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [DIV_W-1:0] dividend_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             zero_q;
  logic             accept;
  logic             cnt_done;
  logic             run_exit;
  logic [DIV_W-1:0] core_quo;
  logic [DIV_W-1:0] core_rem;
  logic [DIV_W-1:0] quo_fixed;
  logic [DIV_W-1:0] rem_fixed;

  assign accept   = (state_q == IDLE) && s_axis_divisor_tvalid && s_axis_dividend_tvalid;
  assign cnt_done = (cnt_q == CNT_W'(DIV_ITER));

`ifdef DIV_ZERO_FASTPATH_EN
  assign run_exit = cnt_done || zero_q;
`else
  assign run_exit = cnt_done;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = RUN;
      RUN:     if (run_exit) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Operand side-information captured at acceptance; magnitudes go straight
  // into the core so the first iteration happens on the next edge.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      dividend_q <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_q     <= 1'b0;
    end else if (accept) begin
      cnt_q      <= '0;
      dividend_q <= s_axis_dividend_tdata;
      neg_quo_q  <= SIGNED && (s_axis_dividend_tdata[DIV_W-1] ^ s_axis_divisor_tdata[DIV_W-1]);
      neg_rem_q  <= SIGNED && s_axis_dividend_tdata[DIV_W-1];
      zero_q     <= (s_axis_divisor_tdata == '0);
    end else if (state_q == RUN) begin
      cnt_q <= run_exit ? '0 : cnt_q + CNT_W'(1);
    end
  end

  div_core_unsigned u_core (
    .aclk      (aclk),
    .resetn    (resetn),
    .load      (accept),
    .step      ((state_q == RUN) && !cnt_done),
    .dividend  (magnitude(s_axis_dividend_tdata, SIGNED)),
    .divisor   (magnitude(s_axis_divisor_tdata, SIGNED)),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

  // Quotient negates when signs differ (truncation toward zero); remainder
  // follows the dividend's sign.
  assign quo_fixed = neg_quo_q ? -core_quo : core_quo;
  assign rem_fixed = neg_rem_q ? -core_rem : core_rem;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tuser  <= 1'b0;
      m_axis_dout_tdata  <= '0;
    end else if ((state_q == RUN) && run_exit) begin
      m_axis_dout_tvalid <= 1'b1;
      m_axis_dout_tuser  <= zero_q;
      m_axis_dout_tdata  <= zero_q ? {dividend_q, {DIV_W{1'b1}}} : {rem_fixed, quo_fixed};
    end else begin
      m_axis_dout_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_divider32.sv
// -----------------------------------------------------------------------------
// tb_seq_divider32
// Drives an unsigned and a signed instance of seq_divider32 from shared
// operand inputs. A behavioural model (plain integer division plus the
// acceptance/latency rules) predicts every cycle's tvalid/tuser/tdata, and
// directed operations pin the model against hand-computed values.
// -----------------------------------------------------------------------------
module tb_seq_divider32;

  localparam int LAT_FULL = 34;
`ifdef DIV_ZERO_FASTPATH_EN
  localparam int LAT_ZERO = 2;
`else
  localparam int LAT_ZERO = 34;
`endif

  logic        aclk = 1'b0;
  logic        resetn = 1'b1;
  logic        divisor_valid = 1'b0;
  logic [31:0] divisor_data = '0;
  logic        dividend_valid = 1'b0;
  logic [31:0] dividend_data = '0;
  logic        tvalid_u, tuser_u, tvalid_s, tuser_s;
  logic [63:0] tdata_u, tdata_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 aclk = ~aclk;

  seq_divider32 #(.SIGNED(1'b0)) u_dut_u (
    .aclk                   (aclk),
    .resetn                 (resetn),
    .s_axis_divisor_tvalid  (divisor_valid),
    .s_axis_divisor_tdata   (divisor_data),
    .s_axis_dividend_tvalid (dividend_valid),
    .s_axis_dividend_tdata  (dividend_data),
    .m_axis_dout_tvalid     (tvalid_u),
    .m_axis_dout_tuser      (tuser_u),
    .m_axis_dout_tdata      (tdata_u)
  );

  seq_divider32 #(.SIGNED(1'b1)) u_dut_s (
    .aclk                   (aclk),
    .resetn                 (resetn),
    .s_axis_divisor_tvalid  (divisor_valid),
    .s_axis_divisor_tdata   (divisor_data),
    .s_axis_dividend_tvalid (dividend_valid),
    .s_axis_dividend_tdata  (dividend_data),
    .m_axis_dout_tvalid     (tvalid_s),
    .m_axis_dout_tuser      (tuser_s),
    .m_axis_dout_tdata      (tdata_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result {tuser, remainder, quotient} from plain integer maths.
  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input bit sgn);
    longint la, lb, q, r;
    if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
    if (!sgn) return {1'b0, a % b, a / b};
    la = longint'($signed(a));
    lb = longint'($signed(b));
    q  = la / lb;
    r  = la % lb;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Model + per-cycle compare
  // ---------------------------------------------------------------------------
  int          cyc = 0;
  int          free_edge = 0;
  int          exp_edge = 0;
  bit          pending = 1'b0;
  logic [64:0] exp_u, exp_s;
  logic [64:0] last_u = '0;
  logic [64:0] last_s = '0;

  always @(posedge aclk) begin
    bit exp_v;
    #1;
    cyc++;
    if (!resetn) begin
      pending   = 1'b0;
      last_u    = '0;
      last_s    = '0;
      free_edge = cyc + 1;
      check("rst tvalid_u", {63'd0, tvalid_u}, 64'd0);
      check("rst tvalid_s", {63'd0, tvalid_s}, 64'd0);
      check("rst tdata_u", tdata_u, 64'd0);
      check("rst tdata_s", tdata_s, 64'd0);
    end else begin
      exp_v = pending && (cyc == exp_edge);
      if (exp_v) begin
        last_u  = exp_u;
        last_s  = exp_s;
        pending = 1'b0;
      end
      check("tvalid_u", {63'd0, tvalid_u}, {63'd0, exp_v});
      check("tvalid_s", {63'd0, tvalid_s}, {63'd0, exp_v});
      check("tdata_u", tdata_u, last_u[63:0]);
      check("tdata_s", tdata_s, last_s[63:0]);
      check("tuser_u", {63'd0, tuser_u}, {63'd0, last_u[64]});
      check("tuser_s", {63'd0, tuser_s}, {63'd0, last_s[64]});
      if (divisor_valid && dividend_valid && cyc >= free_edge) begin
        exp_u     = model(dividend_data, divisor_data, 1'b0);
        exp_s     = model(dividend_data, divisor_data, 1'b1);
        exp_edge  = cyc + ((divisor_data == 0) ? LAT_ZERO : LAT_FULL) - 1;
        free_edge = exp_edge + 2;
        pending   = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'($urandom_range(1, 20));
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation from idle; lat is cycles from acceptance to the
  // result pulse (acceptance cycle counted as 1), -1 if it never came.
  task automatic op(input logic [31:0] a, input logic [31:0] b, input bit scramble,
                    output int lat);
    @(negedge aclk);
    dividend_data  = a;
    divisor_data   = b;
    dividend_valid = 1'b1;
    divisor_valid  = 1'b1;
    @(negedge aclk);
    lat = -1;
    for (int k = 0; k < 60; k++) begin
      if (tvalid_u) begin
        lat = k + 1;
        break;
      end
      if (scramble && k < 20) begin
        dividend_data  = $urandom;
        divisor_data   = $urandom;
        dividend_valid = 1'b1;
        divisor_valid  = 1'b1;
      end else begin
        dividend_valid = 1'b0;
        divisor_valid  = 1'b0;
      end
      @(negedge aclk);
    end
    dividend_valid = 1'b0;
    divisor_valid  = 1'b0;
    repeat (3) @(negedge aclk);
  endtask

  initial begin
    int lat;
    #2 resetn = 1'b0;
    repeat (3) @(negedge aclk);
    resetn = 1'b1;

    op(32'd100, 32'd7, 1'b0, lat);
    check("lat 100/7", 64'(lat), 64'(LAT_FULL));
    check("u 100/7", tdata_u, {32'h0000_0002, 32'h0000_000E});
    check("u 100/7 tuser", {63'd0, tuser_u}, 64'd0);

    op(32'hFFFF_FFF9, 32'd2, 1'b0, lat);
    check("s -7/2", tdata_s, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    op(32'd7, 32'hFFFF_FFFE, 1'b0, lat);
    check("s 7/-2", tdata_s, {32'h0000_0001, 32'hFFFF_FFFD});

    op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat);
    check("s min/-1", tdata_s, {32'h0, 32'h8000_0000});
    check("s min/-1 tuser", {63'd0, tuser_s}, 64'd0);

    op(32'hFFFF_FFFF, 32'd1, 1'b0, lat);
    check("u max/1", tdata_u, {32'h0, 32'hFFFF_FFFF});

    op(32'h1234_5678, 32'd0, 1'b0, lat);
    check("lat div0", 64'(lat), 64'(LAT_ZERO));
    check("u div0", tdata_u, {32'h1234_5678, 32'hFFFF_FFFF});
    check("s div0", tdata_s, {32'h1234_5678, 32'hFFFF_FFFF});
    check("u div0 tuser", {63'd0, tuser_u}, 64'd1);
    check("s div0 tuser", {63'd0, tuser_s}, 64'd1);

    // Operands change (valids high) while busy: only the accepted pair counts.
    op(32'd1000, 32'd10, 1'b1, lat);
    check("lat busy", 64'(lat), 64'(LAT_FULL));
    check("u busy", tdata_u, {32'h0, 32'h0000_0064});

    // Reset ten cycles into an operation.
    @(negedge aclk);
    dividend_data  = 32'hDEAD_BEEF;
    divisor_data   = 32'd3;
    dividend_valid = 1'b1;
    divisor_valid  = 1'b1;
    @(negedge aclk);
    dividend_valid = 1'b0;
    divisor_valid  = 1'b0;
    repeat (9) @(negedge aclk);
    resetn = 1'b0;
    @(negedge aclk);
    check("abort tdata_u", tdata_u, 64'd0);
    check("abort tvalid_u", {63'd0, tvalid_u}, 64'd0);
    resetn = 1'b1;
    repeat (40) @(negedge aclk);
    check("abort hold tdata_s", tdata_s, 64'd0);

    op(32'd50, 32'd5, 1'b0, lat);
    check("lat after abort", 64'(lat), 64'(LAT_FULL));
    check("u 50/5", tdata_u, {32'h0, 32'h0000_000A});

    // Random traffic, including back-to-back accepts and one reset.
    for (int i = 0; i < 3000; i++) begin
      @(negedge aclk);
      dividend_valid = ($urandom_range(0, 3) != 0);
      divisor_valid  = ($urandom_range(0, 3) != 0);
      dividend_data  = rnd_word();
      divisor_data   = rnd_word();
      if (i == 1500) resetn = 1'b0;
      if (i == 1502) resetn = 1'b1;
    end
    dividend_valid = 1'b0;
    divisor_valid  = 1'b0;
    repeat (40) @(negedge aclk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
